// File: rtl/ee354_project_occupancy.sv
// Walks the snake segment ring buffer from tail to head, rebuilds the 225-bit occupancy map
// and flags a next-head self collision. Optional macro OCC_DUP_CHECK_EN adds the Dup_Hit output.
module ee354_project_occupancy #(
  parameter int CELLS = 225,
  parameter int GRID  = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [7:0]       Tail_Ptr,
  input  logic [7:0]       Length,
  input  logic             Grow,
  input  logic [3:0]       Query_X,
  input  logic [3:0]       Query_Y,
  output logic             Rd_En,
  output logic [7:0]       Rd_Addr,
  input  logic [7:0]       Rd_Data,
  output logic             Busy,
  output logic             Done,
  output logic [CELLS-1:0] Cell_Snake_Vector,
  output logic             Self_Hit,
  output logic             Bad_Entry,
`ifdef OCC_DUP_CHECK_EN
  output logic             Dup_Hit,
`endif
  output logic [1:0]       Dbg_State
);

  // Handshakes: Start is taken only while Busy=0 (Done cycle included) and is dropped otherwise;
  // Done pulses once per accepted Start; Rd_Data answers the Rd_En of the previous cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  localparam logic [7:0] CELLS_B   = 8'(CELLS);
  localparam logic [7:0] LAST_ADDR = 8'(CELLS - 1);
  localparam logic [7:0] GRID_B    = 8'(GRID);
  localparam logic [3:0] MAX_C     = 4'(GRID - 1);

  state_t           state_q, state_d;
  logic [7:0]       len_q, cnt_q;
  logic             grow_q;
  logic [3:0]       qx_q, qy_q;
  logic [CELLS-1:0] shadow_q;
  logic             hit_q, err_q;
  logic             rd_vld_q, rd_first_q;
`ifdef OCC_DUP_CHECK_EN
  logic             dup_q;
`endif

  logic [7:0] len_eff, tail_mod, ent_idx;
  logic [3:0] ent_x, ent_y;
  logic       ent_ok, last_rd;

  assign len_eff  = (Length > CELLS_B) ? CELLS_B : Length;
  assign tail_mod = (Tail_Ptr >= CELLS_B) ? (Tail_Ptr - CELLS_B) : Tail_Ptr;
  assign ent_x    = Rd_Data[7:4];
  assign ent_y    = Rd_Data[3:0];
  assign ent_ok   = (ent_x <= MAX_C) && (ent_y <= MAX_C);
  assign ent_idx  = ({4'd0, ent_x} * GRID_B) + {4'd0, ent_y};
  assign last_rd  = (cnt_q == (len_q - 8'd1));

  assign Rd_En     = (state_q == SCAN);
  assign Busy      = (state_q != IDLE);
  assign Dbg_State = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = (len_eff == 8'd0) ? DRAIN : SCAN;
      SCAN:    if (last_rd) state_d = DRAIN;
      DRAIN:   state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      len_q             <= '0;
      cnt_q             <= '0;
      grow_q            <= 1'b0;
      qx_q              <= '0;
      qy_q              <= '0;
      shadow_q          <= '0;
      hit_q             <= 1'b0;
      err_q             <= 1'b0;
      rd_vld_q          <= 1'b0;
      rd_first_q        <= 1'b0;
      Rd_Addr           <= '0;
      Done              <= 1'b0;
      Cell_Snake_Vector <= '0;
      Self_Hit          <= 1'b0;
      Bad_Entry         <= 1'b0;
`ifdef OCC_DUP_CHECK_EN
      dup_q             <= 1'b0;
      Dup_Hit           <= 1'b0;
`endif
    end else begin
      Done       <= 1'b0;
      rd_vld_q   <= Rd_En;
      rd_first_q <= Rd_En && (cnt_q == 8'd0);

      if ((state_q == IDLE) && Start) begin
        len_q    <= len_eff;
        cnt_q    <= '0;
        grow_q   <= Grow;
        qx_q     <= Query_X;
        qy_q     <= Query_Y;
        shadow_q <= '0;
        hit_q    <= 1'b0;
        err_q    <= 1'b0;
`ifdef OCC_DUP_CHECK_EN
        dup_q    <= 1'b0;
`endif
        // An empty scan issues no reads, so the address port keeps its old value.
        if (len_eff != 8'd0) Rd_Addr <= tail_mod;
      end

      if ((state_q == SCAN) && !last_rd) begin
        cnt_q   <= cnt_q + 8'd1;
        Rd_Addr <= (Rd_Addr == LAST_ADDR) ? 8'd0 : (Rd_Addr + 8'd1);
      end

      // The tail entry only collides when it stays put this move.
      if (rd_vld_q) begin
        if (ent_ok) begin
          shadow_q[ent_idx] <= 1'b1;
          if ((ent_x == qx_q) && (ent_y == qy_q) && (!rd_first_q || grow_q)) hit_q <= 1'b1;
`ifdef OCC_DUP_CHECK_EN
          if (shadow_q[ent_idx]) dup_q <= 1'b1;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end

      if (state_q == PUBLISH) begin
        Cell_Snake_Vector <= shadow_q;
        Self_Hit          <= hit_q;
        Bad_Entry         <= err_q;
        Done              <= 1'b1;
`ifdef OCC_DUP_CHECK_EN
        Dup_Hit           <= dup_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ee354_project_occupancy.sv
// Randomized and directed bench for ee354_project_occupancy against a loop-based reference model
// of the scan rules; checks map, collision flags, read-address sequence and Start/Busy/Done timing.
module tb_ee354_project_occupancy;

  localparam int CELLS = 225;
  localparam int GRID  = 15;
  typedef logic [255:0] cv_t;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [7:0]       Tail_Ptr = '0;
  logic [7:0]       Length = '0;
  logic             Grow = 1'b0;
  logic [3:0]       Query_X = '0;
  logic [3:0]       Query_Y = '0;
  logic             Rd_En;
  logic [7:0]       Rd_Addr;
  logic [7:0]       Rd_Data = '0;
  logic             Busy;
  logic             Done;
  logic [CELLS-1:0] Cell_Snake_Vector;
  logic             Self_Hit;
  logic             Bad_Entry;
  logic [1:0]       Dbg_State;
`ifdef OCC_DUP_CHECK_EN
  logic             Dup_Hit;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]       mem [CELLS];
  logic [7:0]       exp_q[$];
  logic [7:0]       got_q[$];
  logic [CELLS-1:0] exp_map = '0;
  logic             exp_hit = 1'b0, exp_err = 1'b0, exp_dup = 1'b0;
  logic [7:0]       last_addr = '0;
  logic [CELLS-1:0] nx_map;
  logic             nx_hit, nx_err, nx_dup;

  ee354_project_occupancy #(.CELLS(CELLS), .GRID(GRID)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Start             (Start),
    .Tail_Ptr          (Tail_Ptr),
    .Length            (Length),
    .Grow              (Grow),
    .Query_X           (Query_X),
    .Query_Y           (Query_Y),
    .Rd_En             (Rd_En),
    .Rd_Addr           (Rd_Addr),
    .Rd_Data           (Rd_Data),
    .Busy              (Busy),
    .Done              (Done),
    .Cell_Snake_Vector (Cell_Snake_Vector),
    .Self_Hit          (Self_Hit),
    .Bad_Entry         (Bad_Entry),
`ifdef OCC_DUP_CHECK_EN
    .Dup_Hit           (Dup_Hit),
`endif
    .Dbg_State         (Dbg_State)
  );

  // Clock and buffer model: one-cycle synchronous read.
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (Rd_En) Rd_Data <= mem[Rd_Addr];
  always @(negedge Clk) if (Rd_En) got_q.push_back(Rd_Addr);

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pub(input string tag);
    check({tag, "_map"}, cv_t'(Cell_Snake_Vector), cv_t'(exp_map));
    check({tag, "_hit"}, cv_t'(Self_Hit), cv_t'(exp_hit));
    check({tag, "_bad"}, cv_t'(Bad_Entry), cv_t'(exp_err));
`ifdef OCC_DUP_CHECK_EN
    check({tag, "_dup"}, cv_t'(Dup_Hit), cv_t'(exp_dup));
`endif
  endtask

  // Reference: walk L entries from the tail and apply the occupancy rules directly.
  task automatic model(input logic [7:0] tail, input logic [7:0] len, input logic g,
                       input logic [3:0] qx, input logic [3:0] qy);
    int l, base, a, x, y;
    l    = (int'(len) > CELLS) ? CELLS : int'(len);
    base = int'(tail) % CELLS;
    nx_map = '0; nx_hit = 1'b0; nx_err = 1'b0; nx_dup = 1'b0;
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      a = (base + i) % CELLS;
      exp_q.push_back(8'(a));
      x = int'(mem[a][7:4]);
      y = int'(mem[a][3:0]);
      if (x < GRID && y < GRID) begin
        if (nx_map[x*GRID + y]) nx_dup = 1'b1;
        nx_map[x*GRID + y] = 1'b1;
        if (x == int'(qx) && y == int'(qy) && (i != 0 || g)) nx_hit = 1'b1;
      end else begin
        nx_err = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge; returns at the falling edge inside the Done cycle.
  task automatic do_scan(input logic [7:0] tail, input logic [7:0] len, input logic g,
                         input logic [3:0] qx, input logic [3:0] qy, input bit extra_start);
    int l, n_done, done_at, n;
    l = (int'(len) > CELLS) ? CELLS : int'(len);
    model(tail, len, g, qx, qy);
    got_q.delete();
    Tail_Ptr = tail; Length = len; Grow = g; Query_X = qx; Query_Y = qy; Start = 1'b1;
    @(posedge Clk);
    n_done = 0; done_at = -1;
    for (int off = 0; off <= l + 2; off++) begin
      @(negedge Clk);
      if (off == 0) begin
        Start = 1'b0;
        Tail_Ptr = 8'($urandom); Length = 8'($urandom); Grow = 1'($urandom);
        Query_X = 4'($urandom); Query_Y = 4'($urandom);
        check("busy_after_start", cv_t'(Busy), cv_t'(1));
      end
      if (off == 1) begin
        check_pub("hold");
        if (extra_start) Start = 1'b1;
      end
      if (off == 2) Start = 1'b0;
      if (Done) begin
        n_done++;
        if (done_at < 0) done_at = off;
      end
    end
    check("done_latency", cv_t'(done_at), cv_t'(l + 2));
    check("done_count", cv_t'(n_done), cv_t'(1));
    check("busy_in_done", cv_t'(Busy), cv_t'(0));
    exp_map = nx_map; exp_hit = nx_hit; exp_err = nx_err; exp_dup = nx_dup;
    check_pub("pub");
    check("addr_count", cv_t'(got_q.size()), cv_t'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("addr_seq", cv_t'(got_q[i]), cv_t'(exp_q[i]));
    if (exp_q.size() > 0) last_addr = exp_q[$];
  endtask

  task automatic idle_check(input int cycles);
    int n_done;
    n_done = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge Clk);
      if (Done) n_done++;
    end
    check("idle_no_done", cv_t'(n_done), cv_t'(0));
    check("idle_busy", cv_t'(Busy), cv_t'(0));
    check("idle_addr_hold", cv_t'(Rd_Addr), cv_t'(last_addr));
    check_pub("idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_map"}, cv_t'(Cell_Snake_Vector), cv_t'(0));
    check({tag, "_hit"}, cv_t'(Self_Hit), cv_t'(0));
    check({tag, "_bad"}, cv_t'(Bad_Entry), cv_t'(0));
    check({tag, "_busy"}, cv_t'(Busy), cv_t'(0));
    check({tag, "_done"}, cv_t'(Done), cv_t'(0));
    check({tag, "_rden"}, cv_t'(Rd_En), cv_t'(0));
    check({tag, "_addr"}, cv_t'(Rd_Addr), cv_t'(0));
    check({tag, "_state"}, cv_t'(Dbg_State), cv_t'(0));
`ifdef OCC_DUP_CHECK_EN
    check({tag, "_dup"}, cv_t'(Dup_Hit), cv_t'(0));
`endif
  endtask

  task automatic reset_mid_scan();
    Tail_Ptr = 8'd20; Length = 8'd10; Grow = 1'b0; Query_X = '0; Query_Y = '0; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check_reset_outputs("mid_reset");
    exp_map = '0; exp_hit = 1'b0; exp_err = 1'b0; exp_dup = 1'b0; last_addr = '0;
    @(negedge Clk);
    Reset = 1'b0;
    idle_check(4);
  endtask

  function automatic logic [7:0] rand_entry();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'hFF;
    if (r == 1) return {4'($urandom_range(15, 15)), 4'($urandom_range(0, 15))};
    return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
  endfunction

  initial begin
    logic [7:0] len;
    for (int i = 0; i < CELLS; i++) mem[i] = 8'hFF;
    mem[0] = 8'h86; mem[1] = 8'h87; mem[2] = 8'h88;

    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge Clk);

    // Basic map, then back-to-back scans starting in each Done cycle.
    do_scan(8'd0, 8'd3, 1'b0, 4'd0, 4'd0, 1'b0);
    check("tp_map_bits", cv_t'(Cell_Snake_Vector), cv_t'(7) << 126);
    do_scan(8'd0, 8'd3, 1'b0, 4'd8, 4'd7, 1'b0);
    check("tp_hit_body", cv_t'(Self_Hit), cv_t'(1));
    do_scan(8'd0, 8'd3, 1'b0, 4'd8, 4'd6, 1'b0);
    check("tp_tail_nogrow", cv_t'(Self_Hit), cv_t'(0));
    do_scan(8'd0, 8'd3, 1'b1, 4'd8, 4'd6, 1'b0);
    check("tp_tail_grow", cv_t'(Self_Hit), cv_t'(1));

    // Invalid entry skipped, then a clean scan with an ignored mid-scan Start.
    mem[1] = 8'hFF;
    do_scan(8'd0, 8'd3, 1'b0, 4'd0, 4'd0, 1'b0);
    check("tp_bad_flag", cv_t'(Bad_Entry), cv_t'(1));
    check("tp_bad_map", cv_t'(Cell_Snake_Vector), (cv_t'(1) << 126) | (cv_t'(1) << 128));
    mem[1] = 8'h87;
    do_scan(8'd0, 8'd3, 1'b0, 4'd0, 4'd0, 1'b1);
    check("tp_clean_flag", cv_t'(Bad_Entry), cv_t'(0));
    idle_check(3);

    // Empty scan.
    do_scan(8'd7, 8'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("tp_len0_map", cv_t'(Cell_Snake_Vector), cv_t'(0));
    idle_check(2);

    // Wrap from 223 through 0.
    mem[223] = 8'h11; mem[224] = 8'h12; mem[0] = 8'h13; mem[1] = 8'h14;
    do_scan(8'd223, 8'd4, 1'b0, 4'd0, 4'd0, 1'b0);
    check("tp_wrap_map", cv_t'(Cell_Snake_Vector), cv_t'(15) << 16);

    reset_mid_scan();
    do_scan(8'd223, 8'd4, 1'b0, 4'd1, 4'd3, 1'b0);
    check("tp_after_reset_hit", cv_t'(Self_Hit), cv_t'(1));

    // Duplicate coordinates.
    mem[10] = 8'h55; mem[11] = 8'h55; mem[12] = 8'h56;
    do_scan(8'd10, 8'd3, 1'b0, 4'd0, 4'd0, 1'b0);
    check("tp_dup_map", cv_t'(Cell_Snake_Vector), cv_t'(3) << 80);
`ifdef OCC_DUP_CHECK_EN
    check("tp_dup_flag", cv_t'(Dup_Hit), cv_t'(1));
`endif

    // Randomized scans over a crowded region to provoke hits, duplicates and bad entries.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < CELLS; i++) mem[i] = rand_entry();
      len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 30));
      do_scan(8'($urandom), len, 1'($urandom), 4'($urandom_range(0, 5)),
              4'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
